// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (instruction port, data port) to one-slave memory
// arbiter with round-robin tie breaking, a registered slave request and a
// per-transaction timeout so a silent slave can never wedge the CPU.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   imemory_* / dmemory_*         master ports: valid/instr/addr/wdata/wstrb in,
//                                 rdata/ready out (ready is a one-cycle pulse)
//   mem_valid/instr/addr/wdata/wstrb  registered slave request
//   mem_rdata, mem_ready          slave response
//   bus_timeout                   one-cycle pulse on forced completion
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_ready,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state, state_nxt;
  logic          last_d, last_d_nxt;   // 1: data port won the most recent tie
  logic [CW-1:0] cnt;
  logic          grant_i, grant_d;
  logic          timeout_hit, done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    last_d_nxt    = last_d;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    imemory_ready = 1'b0;
    imemory_rdata = '0;
    dmemory_ready = 1'b0;
    dmemory_rdata = '0;
    // A ready on the deadline cycle wins over the timeout.
    timeout_hit   = (state != IDLE) && !mem_ready && (cnt == CNT_LAST);
    done          = (state != IDLE) && (mem_ready || timeout_hit);
    bus_timeout   = timeout_hit;
    case (state)
      IDLE: begin
        if (imemory_valid && dmemory_valid) begin
          grant_i    = last_d;
          grant_d    = !last_d;
          last_d_nxt = !last_d;
        end else begin
          grant_i = imemory_valid;
          grant_d = dmemory_valid;
        end
        if (grant_i)      state_nxt = BUSY_I;
        else if (grant_d) state_nxt = BUSY_D;
      end
      BUSY_I: begin
        if (done) begin
          imemory_ready = 1'b1;
          imemory_rdata = mem_ready ? mem_rdata : '0;
          state_nxt     = IDLE;
        end
      end
      BUSY_D: begin
        if (done) begin
          dmemory_ready = 1'b1;
          dmemory_rdata = mem_ready ? mem_rdata : '0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers and timeout counter. The counter stops at CNT_LAST,
  // which is also the cycle the timeout completes the transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      cnt       <= '0;
    end else begin
      if (grant_i) begin
        mem_valid <= 1'b1;
        mem_instr <= imemory_instr;
        mem_addr  <= imemory_addr;
        mem_wdata <= imemory_wdata;
        mem_wstrb <= imemory_wstrb;
      end else if (grant_d) begin
        mem_valid <= 1'b1;
        mem_instr <= dmemory_instr;
        mem_addr  <= dmemory_addr;
        mem_wdata <= dmemory_wdata;
        mem_wstrb <= dmemory_wstrb;
      end else if (done) begin
        mem_valid <= 1'b0;
      end

      if (grant_i || grant_d)
        cnt <= '0;
      else if ((state != IDLE) && !mem_ready && (cnt != CNT_LAST))
        cnt <= cnt + CW'(1);
    end
  end

endmodule
